router_pkt_tx: RTL and testbench

- Packet source that drives the router's input port: emits header, payload and parity bytes on data_out with pkt_valid, and honours the router's busy.
- Payload bytes are pre-loaded into an internal FIFO over a valid/ready interface. A packet is launched only when its whole payload is buffered, so pkt_valid never drops mid-payload.
- Sits in front of the 1x3 router in the top-level/testbench harness.

---
 rtl/router_pkg.sv | 23 ++
 rtl/router_tx_fifo.sv | 49 ++++
 rtl/router_pkt_tx.sv | 205 ++++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router packet source: FSM encoding, header layout
// and destination/length limits.
package router_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HEADER  = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_PARITY  = 3'd3,
      ST_DROP    = 3'd4,
      ST_GAP     = 3'd5
   } tx_state_t;

   localparam logic [1:0] ADDR_ILLEGAL = 2'b11;
   localparam int         MAX_LEN      = 63;

   // Header byte: length in [7:2], destination in [1:0].
   function automatic logic [7:0] make_header(input logic [5:0] len,
                                              input logic [1:0] addr);
      return {len, addr};
   endfunction

endpackage

// File: rtl/router_tx_fifo.sv
// First-word-fall-through synchronous FIFO holding payload bytes until a
// whole packet is available.
module router_tx_fifo #(
   parameter int DEPTH  = 64,
   parameter int DATA_W = 8
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     push,
   input  logic [DATA_W-1:0]        push_data,
   input  logic                     pop,
   output logic [DATA_W-1:0]        pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clock) begin
      if (resetn && do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the router input port: buffers payload, then emits
// header, payload and parity while honouring busy, with a busy-timeout abort.
module router_pkt_tx
   import router_pkg::*;
#(
   parameter int DEPTH        = 64,
   parameter int BUSY_TIMEOUT = 64,
   parameter int GAP_CYCLES   = 2
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic [7:0]             pl_data,
   input  logic                   pl_valid,
   output logic                   pl_ready,
   input  logic                   start,
   input  logic [1:0]             dest_addr,
   input  logic [5:0]             payload_len,
   output logic                   tx_ready,
   input  logic                   busy,
   output logic                   pkt_valid,
   output logic [7:0]             data_out,
   output logic                   tx_done,
   output logic                   tx_abort,
   output logic                   req_err,
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int BW = $clog2(BUSY_TIMEOUT + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   tx_state_t   state, state_d;
   logic [5:0]  len_q, len_d;
   logic [5:0]  remaining_q, remaining_d;
   logic [5:0]  drop_q, drop_d;
   logic [7:0]  parity_q, parity_d;
   logic [BW-1:0] busy_cnt_q, busy_cnt_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [7:0]  data_d;
   logic        pv_d, done_d, abort_d, err_d;
   logic        fifo_pop, fifo_full, fifo_empty;
   logic [7:0]  fifo_rd;
   logic [7:0]  hdr;
   logic        start_ok;
   logic        timeout;
   logic        sending;

   router_tx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) u_fifo (
      .clock     (clock),
      .resetn    (resetn),
      .push      (pl_valid),
      .push_data (pl_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_rd),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign pl_ready = !fifo_full;
   assign tx_ready = (state == ST_IDLE);
   assign hdr      = make_header(payload_len, dest_addr);
   assign sending  = (state == ST_HEADER) || (state == ST_PAYLOAD) || (state == ST_PARITY);
   assign timeout  = sending && busy && (busy_cnt_q == BW'(BUSY_TIMEOUT - 1));

   // Launch only when the whole payload is already buffered.
   assign start_ok = (payload_len != '0) && (int'(payload_len) <= MAX_LEN) &&
                     (dest_addr != ADDR_ILLEGAL) && (CW'(payload_len) <= fifo_count);

   always_ff @(posedge clock) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         ST_IDLE:    if (start && start_ok) state_d = ST_HEADER;
         ST_HEADER: begin
            if (timeout)    state_d = ST_DROP;
            else if (!busy) state_d = ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            if (timeout)                            state_d = (remaining_q > 6'd1) ? ST_DROP : ST_GAP;
            else if (!busy && remaining_q <= 6'd1) state_d = ST_PARITY;
         end
         ST_PARITY:  if (timeout || !busy) state_d = ST_GAP;
         ST_DROP:    if (drop_q <= 6'd1) state_d = ST_GAP;
         ST_GAP:     if (gap_q == GW'(GAP_CYCLES - 1)) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      fifo_pop    = 1'b0;
      data_d      = data_out;
      pv_d        = pkt_valid;
      done_d      = 1'b0;
      abort_d     = 1'b0;
      err_d       = 1'b0;
      parity_d    = parity_q;
      remaining_d = remaining_q;
      drop_d      = drop_q;
      len_d       = len_q;
      busy_cnt_d  = busy_cnt_q;
      gap_d       = '0;
      case (state)
         ST_IDLE: begin
            data_d = '0;
            pv_d   = 1'b0;
            if (start) begin
               if (start_ok) begin
                  data_d     = hdr;
                  pv_d       = 1'b1;
                  parity_d   = hdr;
                  len_d      = payload_len;
                  busy_cnt_d = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_HEADER, ST_PAYLOAD, ST_PARITY: begin
            if (busy) begin
               if (timeout) begin
                  abort_d    = 1'b1;
                  pv_d       = 1'b0;
                  data_d     = '0;
                  busy_cnt_d = '0;
                  // The byte on data_out in PAYLOAD was already popped.
                  drop_d     = (state == ST_HEADER) ? len_q : remaining_q - 6'd1;
               end else begin
                  busy_cnt_d = busy_cnt_q + 1'b1;
               end
            end else begin
               busy_cnt_d = '0;
               if (state == ST_HEADER) begin
                  fifo_pop    = 1'b1;
                  data_d      = fifo_rd;
                  remaining_d = len_q;
               end else if (state == ST_PAYLOAD) begin
                  parity_d = parity_q ^ data_out;
                  if (remaining_q > 6'd1) begin
                     fifo_pop    = 1'b1;
                     data_d      = fifo_rd;
                     remaining_d = remaining_q - 6'd1;
                  end else begin
                     data_d      = parity_q ^ data_out;
                     pv_d        = 1'b0;
                     remaining_d = '0;
                  end
               end else begin
                  done_d = 1'b1;
                  data_d = '0;
               end
            end
         end
         ST_DROP: begin
            fifo_pop = !fifo_empty;
            drop_d   = drop_q - 6'd1;
            data_d   = '0;
            pv_d     = 1'b0;
         end
         ST_GAP: begin
            data_d = '0;
            pv_d   = 1'b0;
            gap_d  = gap_q + 1'b1;
         end
         default: begin
            data_d = '0;
            pv_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         pkt_valid   <= 1'b0;
         data_out    <= '0;
         tx_done     <= 1'b0;
         tx_abort    <= 1'b0;
         req_err     <= 1'b0;
         remaining_q <= '0;
         drop_q      <= '0;
         busy_cnt_q  <= '0;
         gap_q       <= '0;
      end else begin
         pkt_valid   <= pv_d;
         data_out    <= data_d;
         tx_done     <= done_d;
         tx_abort    <= abort_d;
         req_err     <= err_d;
         remaining_q <= remaining_d;
         drop_q      <= drop_d;
         busy_cnt_q  <= busy_cnt_d;
         gap_q       <= gap_d;
      end
   end

   always_ff @(posedge clock) begin
      parity_q <= parity_d;
      len_q    <= len_d;
   end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: queue-based payload model, per-packet expected
// byte streams computed from the header/payload/parity rules.
module tb_router_pkt_tx;

   localparam int DEPTH        = 64;
   localparam int BUSY_TIMEOUT = 64;
   localparam int GAP_CYCLES   = 2;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] pl_data = '0;
   logic       pl_valid = 1'b0;
   logic       pl_ready;
   logic       start = 1'b0;
   logic [1:0] dest_addr = '0;
   logic [5:0] payload_len = '0;
   logic       tx_ready;
   logic       busy = 1'b0;
   logic       pkt_valid;
   logic [7:0] data_out;
   logic       tx_done;
   logic       tx_abort;
   logic       req_err;
   logic [6:0] fifo_count;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] model_q[$];

   router_pkt_tx #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BUSY_TIMEOUT), .GAP_CYCLES(GAP_CYCLES)) dut (
      .clock(clock), .resetn(resetn), .pl_data(pl_data), .pl_valid(pl_valid),
      .pl_ready(pl_ready), .start(start), .dest_addr(dest_addr),
      .payload_len(payload_len), .tx_ready(tx_ready), .busy(busy),
      .pkt_valid(pkt_valid), .data_out(data_out), .tx_done(tx_done),
      .tx_abort(tx_abort), .req_err(req_err), .fifo_count(fifo_count)
   );

   always #5 clock = ~clock;

   // One clock; a byte offered while pl_ready is high enters the model queue.
   task automatic step();
      logic       acc;
      logic [7:0] d;
      acc = pl_valid && pl_ready && resetn;
      d   = pl_data;
      @(posedge clock);
      if (acc) model_q.push_back(d);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      pl_valid = 1'b1;
      pl_data  = b;
      step();
      pl_valid = 1'b0;
   endtask

   task automatic send_pkt(input string tag, input logic [1:0] addr, input int len,
                           input int hold_at, input int hold_n, input bit rnd_busy,
                           input bit push_en);
      logic [7:0] exp_b[$];
      logic [7:0] par, exp_d;
      logic       exp_pv;
      int idx, held;
      bit b, done;
      exp_b.push_back({len[5:0], addr});
      par = {len[5:0], addr};
      for (int i = 0; i < len; i++) begin
         exp_b.push_back(model_q.pop_front());
         par = par ^ exp_b[i + 1];
      end
      n_cmp++;
      if (tx_ready !== 1'b1) begin n_err++; $display("FAIL %s_ready_before: got %b want 1", tag, tx_ready); end
      start = 1'b1; dest_addr = addr; payload_len = len[5:0];
      step();
      start = 1'b0;
      idx = 0; held = 0; done = 0;
      for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
         exp_pv = (idx <= len);
         exp_d  = (idx <= len) ? exp_b[idx] : par;
         n_cmp++;
         if (pkt_valid !== exp_pv || data_out !== exp_d) begin
            n_err++;
            $display("FAIL %s_stream idx=%0d: got pv=%b d=%02h want pv=%b d=%02h", tag, idx, pkt_valid, data_out, exp_pv, exp_d);
         end
         b = 1'b0;
         if (idx == hold_at && held < hold_n) begin b = 1'b1; held++; end
         else if (rnd_busy) b = ($urandom_range(0, 3) == 0);
         busy = b;
         if (push_en) begin pl_valid = 1'b1; pl_data = 8'($urandom); end
         step();
         if (!b) begin
            if (idx == len + 1) done = 1;
            else idx++;
         end
      end
      busy = 1'b0; pl_valid = 1'b0;
      n_cmp++;
      if (!done) begin n_err++; $display("FAIL %s_timeout: got idx=%0d want %0d", tag, idx, len + 1); end
      n_cmp++;
      if (tx_done !== 1'b1 || pkt_valid !== 1'b0 || data_out !== 8'h00) begin
         n_err++; $display("FAIL %s_done: got done=%b pv=%b d=%02h want 1 0 00", tag, tx_done, pkt_valid, data_out);
      end
      n_cmp++;
      if (fifo_count !== 7'(model_q.size())) begin n_err++; $display("FAIL %s_count: got %0d want %0d", tag, fifo_count, model_q.size()); end
      n_cmp++;
      if (tx_ready !== 1'b0) begin n_err++; $display("FAIL %s_gap_ready: got %b want 0", tag, tx_ready); end
      repeat (GAP_CYCLES) step();
      n_cmp++;
      if (tx_ready !== 1'b1 || tx_done !== 1'b0) begin
         n_err++; $display("FAIL %s_idle: got ready=%b done=%b want 1 0", tag, tx_ready, tx_done);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) step();
      resetn = 1'b1;
      step();
      n_cmp++;
      if (pkt_valid !== 1'b0 || data_out !== 8'h00) begin n_err++; $display("FAIL reset_out: got pv=%b d=%02h want 0 00", pkt_valid, data_out); end
      n_cmp++;
      if ({tx_done, tx_abort, req_err} !== 3'b000) begin n_err++; $display("FAIL reset_pulses: got %b want 000", {tx_done, tx_abort, req_err}); end
      n_cmp++;
      if (fifo_count !== 7'd0 || pl_ready !== 1'b1 || tx_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_state: got cnt=%0d plr=%b txr=%b want 0 1 1", fifo_count, pl_ready, tx_ready);
      end
   endtask

   task automatic test_basic();
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
      n_cmp++;
      if (fifo_count !== 7'd3) begin n_err++; $display("FAIL basic_load: got %0d want 3", fifo_count); end
      send_pkt("basic", 2'd1, 3, -1, 0, 1'b0, 1'b0);
   endtask

   task automatic test_busy_hold();
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
      send_pkt("busyhold", 2'd1, 3, 1, 4, 1'b0, 1'b0);
   endtask

   task automatic test_req_err();
      logic [5:0] lens [3];
      logic [1:0] addrs [3];
      lens[0] = 6'd0; addrs[0] = 2'd1;
      lens[1] = 6'd1; addrs[1] = 2'd3;
      lens[2] = 6'd5; addrs[2] = 2'd0;
      push_byte(8'($urandom)); push_byte(8'($urandom));
      for (int k = 0; k < 3; k++) begin
         start = 1'b1; payload_len = lens[k]; dest_addr = addrs[k];
         step();
         start = 1'b0;
         n_cmp++;
         if (req_err !== 1'b1 || pkt_valid !== 1'b0 || fifo_count !== 7'd2) begin
            n_err++; $display("FAIL req_err_%0d: got err=%b pv=%b cnt=%0d want 1 0 2", k, req_err, pkt_valid, fifo_count);
         end
         step();
         n_cmp++;
         if (req_err !== 1'b0 || tx_ready !== 1'b1) begin
            n_err++; $display("FAIL req_err_clear_%0d: got err=%b txr=%b want 0 1", k, req_err, tx_ready);
         end
      end
      send_pkt("after_err", 2'd2, 2, -1, 0, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      int n;
      for (int p = 0; p < 4; p++) begin
         n = $urandom_range(1, 20);
         for (int i = 0; i < n; i++) push_byte(8'($urandom));
         send_pkt("b2b", 2'($urandom_range(0, 2)), n, -1, 0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_full();
      logic exp_rdy;
      for (int i = 0; i < 65; i++) begin
         exp_rdy = (model_q.size() < DEPTH);
         n_cmp++;
         if (pl_ready !== exp_rdy) begin n_err++; $display("FAIL full_ready_%0d: got %b want %b", i, pl_ready, exp_rdy); end
         push_byte(8'($urandom));
      end
      n_cmp++;
      if (fifo_count !== 7'(model_q.size()) || model_q.size() != DEPTH || pl_ready !== 1'b0) begin
         n_err++; $display("FAIL full_count: got cnt=%0d plr=%b want %0d 0", fifo_count, pl_ready, DEPTH);
      end
      send_pkt("pushpop", 2'd0, 63, -1, 0, 1'b1, 1'b1);
   endtask

   task automatic test_reset_mid();
      while (model_q.size() < 5) push_byte(8'($urandom));
      start = 1'b1; payload_len = 6'd5; dest_addr = 2'd0;
      step();
      start = 1'b0;
      step(); step();
      n_cmp++;
      if (pkt_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre: got pv=%b want 1", pkt_valid); end
      resetn = 1'b0;
      step();
      n_cmp++;
      if (pkt_valid !== 1'b0 || data_out !== 8'h00 || fifo_count !== 7'd0) begin
         n_err++; $display("FAIL midrst_out: got pv=%b d=%02h cnt=%0d want 0 00 0", pkt_valid, data_out, fifo_count);
      end
      resetn = 1'b1;
      model_q.delete();
      step();
      n_cmp++;
      if (tx_ready !== 1'b1 || pl_ready !== 1'b1 || fifo_count !== 7'd0) begin
         n_err++; $display("FAIL midrst_release: got txr=%b plr=%b cnt=%0d want 1 1 0", tx_ready, pl_ready, fifo_count);
      end
   endtask

   task automatic test_abort();
      logic [7:0] third;
      bit ok, back;
      for (int i = 0; i < 10; i++) push_byte(8'($urandom));
      third = model_q[2];
      start = 1'b1; payload_len = 6'd10; dest_addr = 2'd2;
      step();
      start = 1'b0;
      busy = 1'b0;
      repeat (3) step();
      n_cmp++;
      if (data_out !== third || pkt_valid !== 1'b1 || fifo_count !== 7'd7) begin
         n_err++; $display("FAIL abort_pre: got d=%02h pv=%b cnt=%0d want %02h 1 7", data_out, pkt_valid, fifo_count, third);
      end
      busy = 1'b1;
      ok = 1;
      for (int i = 0; i < BUSY_TIMEOUT - 1; i++) begin
         step();
         if (tx_abort !== 1'b0 || pkt_valid !== 1'b1 || data_out !== third) ok = 0;
      end
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL abort_hold: got early abort or changed byte, want %02h held", third); end
      step();
      n_cmp++;
      if (tx_abort !== 1'b1 || pkt_valid !== 1'b0 || data_out !== 8'h00) begin
         n_err++; $display("FAIL abort_pulse: got ab=%b pv=%b d=%02h want 1 0 00", tx_abort, pkt_valid, data_out);
      end
      busy = 1'b0;
      repeat (10) model_q.delete(0);
      back = 0;
      for (int i = 0; i < 100 && !back; i++) begin
         step();
         if (tx_ready === 1'b1) back = 1;
      end
      n_cmp++;
      if (!back || fifo_count !== 7'(model_q.size()) || tx_abort !== 1'b0) begin
         n_err++; $display("FAIL abort_recover: got idle=%b cnt=%0d ab=%b want 1 %0d 0", back, fifo_count, tx_abort, model_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_busy_hold();
      test_req_err();
      test_back_to_back();
      test_full();
      test_reset_mid();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
